// File: rtl/wbq_pkg.sv
// Shared types and default sizing for the register-bank write-back queue.
package wbq_pkg;

  localparam int unsigned DEF_M      = 32;
  localparam int unsigned DEF_N_REGS = 16;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_AW     = $clog2(DEF_N_REGS);

  typedef struct packed {
    logic                valid;
    logic [DEF_AW-1:0]   addr;
    logic [DEF_M-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer, bank-write and operand-forwarding signals of the write-back queue.
interface regfile_wb_queue_if
  import wbq_pkg::*;
#(
  parameter int unsigned M      = DEF_M,
  parameter int unsigned N_REGS = DEF_N_REGS,
  parameter int unsigned DEPTH  = DEF_DEPTH
);
  localparam int unsigned AW = $clog2(N_REGS);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [M-1:0]  in_data;
  logic          drain_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [M-1:0]  wr_data;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;
  logic [M-1:0]  rd_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output in_valid, in_addr, in_data, drain_en, rd_addr,
    input  in_ready, wr_en, wr_addr, wr_data, rd_hit, rd_data, count, full, empty
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, rd_addr,
    output in_ready, wr_en, wr_addr, wr_data, rd_hit, rd_data, count, full, empty
  );

endinterface

// File: rtl/wbq_fwd_lookup.sv
// Youngest-match search over the circular queue, scanning from head (oldest) to youngest.
module wbq_fwd_lookup #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4
) (
  input  logic [DEPTH-1:0]          valid,
  input  logic [DEPTH-1:0][AW-1:0]  addrs,
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic [AW-1:0]             key,
  input  logic                      skip_head,
  output logic                      hit,
  output logic [$clog2(DEPTH)-1:0]  idx
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] slot;

  // Later (younger) matches overwrite earlier ones, so the last hit wins.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (valid[slot] && (addrs[slot] == key) && !(skip_head && (i == 0))) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register bank with operand forwarding.
// Optional write coalescing into a pending entry is enabled by defining WB_COALESCE_EN.
module regfile_wb_queue
  import wbq_pkg::*;
#(
  parameter int unsigned M      = DEF_M,
  parameter int unsigned N_REGS = DEF_N_REGS,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input logic               clk,
  input logic               reset,
  regfile_wb_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(N_REGS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][M-1:0]  data_q, data_d;
  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;

  logic          empty, full, push, pop, alloc;
  logic          fwd_hit;
  logic [PW-1:0] fwd_idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  // Gating with reset keeps the bank untouched while the queue is being flushed.
  assign pop   = !empty && bus.drain_en && reset;
  assign push  = bus.in_valid && bus.in_ready;

`ifdef WB_COALESCE_EN
  logic          coal_hit;
  logic [PW-1:0] coal_idx;

  // The popping head is excluded: its data is already on its way to the bank.
  wbq_fwd_lookup #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_coal_lookup (
    .valid     (valid_q),
    .addrs     (addr_q),
    .head      (head_q),
    .key       (bus.in_addr),
    .skip_head (pop),
    .hit       (coal_hit),
    .idx       (coal_idx)
  );

  assign bus.in_ready = !full || coal_hit;
  assign alloc        = push && !coal_hit;
`else
  assign bus.in_ready = !full;
  assign alloc        = push;
`endif

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.in_addr;
      data_d[tail_q]  = bus.in_data;
      tail_d          = tail_q + PW'(1);
    end
`ifdef WB_COALESCE_EN
    if (push && coal_hit) begin
      data_d[coal_idx] = bus.in_data;
    end
`endif
    count_d = count_q + CW'(alloc) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  wbq_fwd_lookup #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd_lookup (
    .valid     (valid_q),
    .addrs     (addr_q),
    .head      (head_q),
    .key       (bus.rd_addr),
    .skip_head (1'b0),
    .hit       (fwd_hit),
    .idx       (fwd_idx)
  );

  assign bus.wr_en   = pop;
  assign bus.wr_addr = pop ? addr_q[head_q] : '0;
  assign bus.wr_data = pop ? data_q[head_q] : '0;
  assign bus.rd_hit  = fwd_hit;
  assign bus.rd_data = fwd_hit ? data_q[fwd_idx] : '0;
  assign bus.count   = count_q;
  assign bus.full    = full;
  assign bus.empty   = empty;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literals.
module tb_regfile_wb_queue;
  import wbq_pkg::*;

  localparam int unsigned M      = DEF_M;
  localparam int unsigned N_REGS = DEF_N_REGS;
  localparam int unsigned DEPTH  = DEF_DEPTH;
  localparam int unsigned AW     = $clog2(N_REGS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_queue_if #(.M(M), .N_REGS(N_REGS), .DEPTH(DEPTH)) bus ();

  regfile_wb_queue #(.M(M), .N_REGS(N_REGS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit last_accept = 1'b0;
  wb_entry_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int youngest(input logic [AW-1:0] a, input int lo);
    for (int i = q.size() - 1; i >= lo; i--) if (q[i].addr == a) return i;
    return -1;
  endfunction

  function automatic bit model_pop();
    return reset && bus.drain_en && (q.size() > 0);
  endfunction

  function automatic bit model_ready();
`ifdef WB_COALESCE_EN
    return (q.size() < DEPTH) || (youngest(bus.in_addr, model_pop() ? 1 : 0) >= 0);
`else
    return q.size() < DEPTH;
`endif
  endfunction

  // Compare at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit pop, push;
    int ri, ci;
    wb_entry_t e;
    @(negedge clk);
    pop  = model_pop();
    push = bus.in_valid && model_ready();
    ri   = youngest(bus.rd_addr, 0);
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("empty", 64'(bus.empty), 64'(q.size() == 0));
    chk("full", 64'(bus.full), 64'(q.size() == DEPTH));
    chk("in_ready", 64'(bus.in_ready), 64'(model_ready()));
    chk("wr_en", 64'(bus.wr_en), 64'(pop));
    chk("wr_addr", 64'(bus.wr_addr), pop ? 64'(q[0].addr) : 64'd0);
    chk("wr_data", 64'(bus.wr_data), pop ? 64'(q[0].data) : 64'd0);
    chk("rd_hit", 64'(bus.rd_hit), 64'(ri >= 0));
    chk("rd_data", 64'(bus.rd_data), (ri >= 0) ? 64'(q[ri].data) : 64'd0);
`ifdef WB_COALESCE_EN
    ci = youngest(bus.in_addr, pop ? 1 : 0);
`else
    ci = -1;
`endif
    @(posedge clk);
    if (!reset) begin
      q.delete();
      push = 1'b0;
    end else begin
      if (push) begin
        if (ci >= 0) begin
          e      = q[ci];
          e.data = bus.in_data;
          q[ci]  = e;
        end else begin
          e.valid = 1'b1;
          e.addr  = bus.in_addr;
          e.data  = bus.in_data;
          q.push_back(e);
        end
      end
      if (pop) void'(q.pop_front());
    end
    last_accept = push;
    #1;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [M-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_all();
    bus.in_valid = 1'b0;
    bus.drain_en = 1'b1;
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) cycle();
    chk("drain_done", 64'(bus.empty), 64'd1);
  endtask

  initial begin
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.drain_en = 1'b0;
    bus.rd_addr  = '0;
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_rd_hit", 64'(bus.rd_hit), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);

    // Single write appears at the bank one edge after acceptance.
    bus.drain_en = 1'b1;
    push_one(4'd3, 32'hDEADBEEF);
    #1;
    chk("t1_wr_en", 64'(bus.wr_en), 64'd1);
    chk("t1_wr_addr", 64'(bus.wr_addr), 64'd3);
    chk("t1_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
    cycle();
    chk("t1_empty", 64'(bus.empty), 64'd1);

    // Fill while stalled, then drain in order.
    bus.drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(AW'(i), M'(i * 32'h11));
    #1;
    chk("t2_full", 64'(bus.full), 64'd1);
    chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t2_count", 64'(bus.count), 64'd4);
    push_one(4'd5, 32'h55);
    #1;
    chk("t2_count_after_5th", 64'(bus.count), 64'd4);
    bus.drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_wr_en", 64'(bus.wr_en), 64'd1);
      chk("t2_wr_addr", 64'(bus.wr_addr), 64'(i));
      chk("t2_wr_data", 64'(bus.wr_data), 64'(i * 32'h11));
      cycle();
    end
    chk("t2_empty", 64'(bus.empty), 64'd1);

    // Youngest pending write is forwarded.
    bus.drain_en = 1'b0;
    push_one(4'd5, 32'hA);
    push_one(4'd5, 32'hB);
    bus.rd_addr = 4'd5;
    #1;
    chk("t3_rd_hit", 64'(bus.rd_hit), 64'd1);
    chk("t3_rd_data", 64'(bus.rd_data), 64'hB);
`ifdef WB_COALESCE_EN
    chk("t3_count", 64'(bus.count), 64'd1);
`else
    chk("t3_count", 64'(bus.count), 64'd2);
`endif
    drain_all();

    // Steady push and pop from count 2 walks the pointers around the ring.
    bus.drain_en = 1'b0;
    push_one(4'd6, 32'h600);
    push_one(4'd7, 32'h700);
    bus.drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = AW'(8 + i);
      bus.in_data  = $urandom;
      #1;
      chk("t4_count", 64'(bus.count), 64'd2);
      cycle();
    end
    drain_all();

    // Reset with writes pending discards them.
    bus.drain_en = 1'b0;
    push_one(4'd1, 32'h1001);
    push_one(4'd2, 32'h2002);
    push_one(4'd3, 32'h3003);
    reset        = 1'b0;
    bus.drain_en = 1'b1;
    #1;
    chk("t5_wr_en_in_reset", 64'(bus.wr_en), 64'd0);
    cycle();
    reset       = 1'b1;
    bus.rd_addr = 4'd2;
    #1;
    chk("t5_count", 64'(bus.count), 64'd0);
    chk("t5_rd_hit", 64'(bus.rd_hit), 64'd0);
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic; the producer holds an unaccepted write stable.
    for (int i = 0; i < 3000; i++) begin
      if (!bus.in_valid || last_accept) begin
        bus.in_valid = ($urandom_range(0, 99) < 60);
        bus.in_addr  = AW'($urandom_range(0, 7));
        bus.in_data  = $urandom;
      end
      bus.drain_en = ($urandom_range(0, 99) < 65);
      bus.rd_addr  = AW'($urandom_range(0, 7));
      reset        = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1;
    drain_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
